serial_msg_tx: RTL and testbench
================================

// Module: serial_msg_tx
// PURPOSE
//  Parametrised message sender with an integrated 8N1 UART transmitter (start bit, 8 data bits, 1 stop bit).
//  It streams a MSG_LEN-byte constant string out of txd. Two modes are available: one-shot on a start pulse,
//  or repeating with a programmable idle gap while repeat_en is high. The block sits between the
//  application control logic and the board TXD pin, and replaces hand-coded per-character state machines.
// PARAMETERS
//  CLK_FREQ    50_000_000  input clock frequency, Hz
//  BAUD        115_200     line rate; DIV = CLK_FREQ/BAUD (integer, truncated, DIV>=2) clocks per bit
//  MSG_LEN     4           number of bytes in the message, >=1
//  MSG         {8'h0A,8'h2F,8'h30,8'h40}  packed message, MSG_LEN*8 bits; byte k = MSG[8k+7:8k], byte 0 sent first
//  GAP_CYCLES  0           extra idle-high clocks between messages in repeat mode (0 = back to back)
//  IDXW        max(1,$clog2(MSG_LEN))     width of byte_idx (derived, localparam)
// PORTS
//  clk        in   1     system clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  start      in   1     request one message; sampled only when idle
//  repeat_en  in   1     level; high = resend the message continuously after each completion
//  txd        out  1     serial line, idle high, LSB first
//  busy       out  1     high while a message or an inter-message gap is in progress
//  done       out  1     one-clock pulse after the last stop bit of every message
//  byte_idx   out  IDXW  index of the byte currently on the line
// BEHAVIOUR
//  Reset (async, reset_n=0): txd=1, busy=0, done=0, byte_idx=0, all counters 0, both FSMs in IDLE, immediately.
//  Bit FSM: B_IDLE -> B_START -> B_DATA(x8, LSB first) -> B_STOP -> B_IDLE. Each bit lasts exactly DIV clocks.
//   The baud counter restarts at each frame start, so there is no phase carry-over between frames.
//  Message FSM states: M_IDLE, M_SEND, M_GAP.
//  M_IDLE: busy=0. The FSM moves to M_SEND when (start | repeat_en)=1 at a clock edge, with byte_idx=0.
//   The edge at which the request is accepted is "edge 0". txd goes low (start bit) in the cycle after edge 0,
//   and busy goes high in that same cycle.
//  M_SEND: frames are sent back to back, byte_idx incrementing at each frame boundary.
//   The next start bit follows the previous stop bit with zero idle clocks.
//   After the stop bit of byte MSG_LEN-1: done=1 for one clock, and byte_idx returns to 0.
//   Then: if repeat_en=1 and GAP_CYCLES>0 -> M_GAP. If repeat_en=1 and GAP_CYCLES=0 -> M_SEND;
//   the next start bit begins in the same cycle done is high. If repeat_en=0 -> M_IDLE; busy=0 in the done cycle.
//  M_GAP: txd=1, busy=1, counting GAP_CYCLES clocks. At the end of the count, go to M_SEND
//   (start bit begins in the next cycle). If repeat_en=0 during the gap, abort to M_IDLE; busy=0 in the next cycle.
//  start while busy=1 is ignored (not queued). start in the done cycle of a one-shot is accepted,
//   because the FSM is idle in that cycle.
//  repeat_en falling during M_SEND: the current message always completes. Messages are never truncated.
//  A message always takes MSG_LEN*10*DIV clocks on the line. The counters are sized with $clog2 and must not wrap.
//  txd is driven directly from a register (glitch-free). No combinational path from inputs to outputs.
//  reset_n asserted mid-frame: txd returns to 1 immediately. After release, the block waits for a new request.
// TESTING
//  (bench params CLK_FREQ=8, BAUD=1 -> DIV=8; default MSG "@0/\n")
//  1 Reset: hold reset_n=0 -> txd=1, busy=0, done=0, byte_idx=0; assert reset_n=0 asynchronously mid-cycle -> txd=1 same delta.
//  2 One-shot: start=1 one clock, repeat_en=0 -> txd low cycles 1-8; data bits 0x40 LSB first;
//    bytes 0x40,0x30,0x2F,0x0A decoded; done pulse at cycle 321; busy=0 from 321; byte_idx 0,1,2,3.
//  3 Repeat: repeat_en=1, GAP_CYCLES=5 -> 5 extra high clocks after each final stop bit;
//    done every 325 clocks; busy stays 1 throughout.
//  4 Repeat with GAP_CYCLES=0 -> the next message's start bit coincides with the done cycle; frame period exactly 320 clocks.
//  5 start pulses at cycles 50 and 200 during a one-shot -> ignored, exactly one message sent;
//    start held in the done cycle -> second message starts at cycle 322.
//  6 reset_n=0 at cycle 100 (mid-byte 1) -> txd=1, busy=0 at once; after release with no request, txd stays 1 for 500 clocks.
//    repeat_en dropped at gap clock 2 -> busy=0 next cycle, no further start bit.

Source files
------------

// File: rtl/serial_msg_tx_if.sv
// serial_msg_tx_if
//   Control/status bundle for serial_msg_tx.
//   start      request one message (sampled only while idle)
//   repeat_en  level; high = resend the message after each completion
//   txd        serial line, idle high, LSB first
//   busy       message or inter-message gap in progress
//   done       one-clock pulse after the last stop bit of each message
//   byte_idx   index of the byte currently on the line
//   master: the application side; slave: the transmitter.
interface serial_msg_tx_if #(
    parameter int unsigned IDXW = 2
);
    logic            start;
    logic            repeat_en;
    logic            txd;
    logic            busy;
    logic            done;
    logic [IDXW-1:0] byte_idx;

    modport master (
        output start,
        output repeat_en,
        input  txd,
        input  busy,
        input  done,
        input  byte_idx
    );

    modport slave (
        input  start,
        input  repeat_en,
        output txd,
        output busy,
        output done,
        output byte_idx
    );
endinterface

// File: rtl/serial_msg_tx.sv
// serial_msg_tx
//   Streams a constant MSG_LEN-byte string over an 8N1 UART line, either once
//   per start request or continuously (with GAP_CYCLES idle clocks between
//   messages) while repeat_en is high. Byte 0 = MSG[7:0] is sent first.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      serial_msg_tx_if.slave: start, repeat_en in; txd, busy, done,
//              byte_idx out (all outputs registered)
module serial_msg_tx #(
    parameter int unsigned            CLK_FREQ   = 50_000_000,
    parameter int unsigned            BAUD       = 115_200,
    parameter int unsigned            MSG_LEN    = 4,
    parameter logic [MSG_LEN*8-1:0]   MSG        = {8'h0A, 8'h2F, 8'h30, 8'h40},
    parameter int unsigned            GAP_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    serial_msg_tx_if.slave  bus
);
    localparam int unsigned IDXW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0]   BAUD_LAST = CW'(DIV - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(MSG_LEN - 1);
    localparam logic            HAS_GAP   = (GAP_CYCLES > 0);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_SEND = 2'd1;
    localparam logic [1:0] M_GAP  = 2'd2;

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    logic [7:0]      msg_bytes [MSG_LEN];
    logic [1:0]      m_state;
    logic [1:0]      b_state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      shreg;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_next;
    logic            txd_q;
    logic            busy_q;
    logic            done_q;

    for (genvar k = 0; k < MSG_LEN; k++) begin : g_bytes
        assign msg_bytes[k] = MSG[8*k +: 8];
    end

    assign idx_next     = idx + 1'b1;
    assign bus.txd      = txd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.byte_idx = idx;

    // Every frame start (from idle, gap or the previous stop bit) drives txd
    // low on the same edge and restarts the baud counter, so frames abut with
    // no idle clocks and carry no baud phase from the previous frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state  <= M_IDLE;
            b_state  <= B_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            idx      <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (m_state)
                M_IDLE: begin
                    if (bus.start | bus.repeat_en) begin
                        m_state  <= M_SEND;
                        b_state  <= B_START;
                        baud_cnt <= '0;
                        idx      <= '0;
                        shreg    <= msg_bytes[0];
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                M_SEND: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        case (b_state)
                            B_START: begin
                                b_state <= B_DATA;
                                bit_cnt <= '0;
                                txd_q   <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                            B_DATA: begin
                                if (bit_cnt == 3'd7) begin
                                    b_state <= B_STOP;
                                    txd_q   <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    txd_q   <= shreg[0];
                                    shreg   <= shreg >> 1;
                                end
                            end
                            B_STOP: begin
                                if (idx != IDX_LAST) begin
                                    idx     <= idx_next;
                                    b_state <= B_START;
                                    shreg   <= msg_bytes[idx_next];
                                    txd_q   <= 1'b0;
                                end else begin
                                    done_q <= 1'b1;
                                    idx    <= '0;
                                    if (bus.repeat_en && HAS_GAP) begin
                                        m_state <= M_GAP;
                                        b_state <= B_IDLE;
                                        gap_cnt <= '0;
                                    end else if (bus.repeat_en) begin
                                        b_state <= B_START;
                                        shreg   <= msg_bytes[0];
                                        txd_q   <= 1'b0;
                                    end else begin
                                        m_state <= M_IDLE;
                                        b_state <= B_IDLE;
                                        busy_q  <= 1'b0;
                                    end
                                end
                            end
                            default: begin
                                m_state <= M_IDLE;
                                b_state <= B_IDLE;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
                M_GAP: begin
                    if (!bus.repeat_en) begin
                        m_state <= M_IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        m_state  <= M_SEND;
                        b_state  <= B_START;
                        baud_cnt <= '0;
                        shreg    <= msg_bytes[0];
                        txd_q    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    m_state <= M_IDLE;
                    b_state <= B_IDLE;
                    busy_q  <= 1'b0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_msg_tx.sv
// tb_serial_msg_tx
//   Two instances (gap 5 and gap 0) share the same stimulus; each is compared
//   every cycle against a message-timeline model, plus literal timing pins.
module tb_serial_msg_tx;
    localparam int DIV      = 8;
    localparam int MSG_LEN  = 4;
    localparam int FRAME    = 10 * DIV;
    localparam int MSG_CLKS = MSG_LEN * FRAME;
    localparam logic [31:0] MSG_VAL = 32'h0A2F3040;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start_r = 1'b0;
    logic rep_r   = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_msg_tx_if #(.IDXW(2)) bus_a ();
    serial_msg_tx_if #(.IDXW(2)) bus_b ();

    assign bus_a.start     = start_r;
    assign bus_a.repeat_en = rep_r;
    assign bus_b.start     = start_r;
    assign bus_b.repeat_en = rep_r;

    serial_msg_tx #(
        .CLK_FREQ(8), .BAUD(1), .MSG_LEN(4), .MSG(32'h0A2F3040), .GAP_CYCLES(5)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(bus_a)
    );

    serial_msg_tx #(
        .CLK_FREQ(8), .BAUD(1), .MSG_LEN(4), .MSG(32'h0A2F3040), .GAP_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(bus_b)
    );

    // Model: phase 0 idle, 1 sending at clock pos within the message, 2 gap
    // with gap_left clocks remaining.
    int m_phase [2];
    int m_pos   [2];
    int m_gap   [2];
    bit m_done  [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 5 : 0;
    endfunction

    task automatic model_adv(input int i, input bit st, input bit rp);
        m_done[i] = 1'b0;
        case (m_phase[i])
            0: if (st || rp) begin m_phase[i] = 1; m_pos[i] = 0; end
            1: begin
                if (m_pos[i] < MSG_CLKS - 1) m_pos[i]++;
                else begin
                    m_done[i] = 1'b1;
                    if (rp && gap_of(i) > 0) begin m_phase[i] = 2; m_gap[i] = gap_of(i); end
                    else if (rp) m_pos[i] = 0;
                    else m_phase[i] = 0;
                end
            end
            default: begin
                if (!rp) m_phase[i] = 0;
                else if (m_gap[i] == 1) begin m_phase[i] = 1; m_pos[i] = 0; end
                else m_gap[i]--;
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_pos[i] = 0; m_gap[i] = 0; m_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_adv(i, start_r, rep_r);
        end
    end

    task automatic model_out(input int i, output logic t, output logic b, output int x);
        int byte_n, bit_n;
        logic [31:0] msgv;
        t = 1'b1; b = 1'b0; x = 0;
        if (m_phase[i] == 2) b = 1'b1;
        if (m_phase[i] == 1) begin
            byte_n = m_pos[i] / FRAME;
            bit_n  = (m_pos[i] % FRAME) / DIV;
            msgv   = MSG_VAL >> (8 * byte_n);
            b = 1'b1;
            x = byte_n;
            if (bit_n == 0) t = 1'b0;
            else if (bit_n == 9) t = 1'b1;
            else t = msgv[bit_n-1];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic t, b;
        int x;
        model_out(0, t, b, x);
        chk("a.txd", 32'(bus_a.txd), 32'(t));
        chk("a.busy", 32'(bus_a.busy), 32'(b));
        chk("a.done", 32'(bus_a.done), 32'(m_done[0]));
        chk("a.byte_idx", 32'(bus_a.byte_idx), x);
        model_out(1, t, b, x);
        chk("b.txd", 32'(bus_b.txd), 32'(t));
        chk("b.busy", 32'(bus_b.busy), 32'(b));
        chk("b.done", 32'(bus_b.done), 32'(m_done[1]));
        chk("b.byte_idx", 32'(bus_b.byte_idx), x);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] rx [4];
        int early_done, a_d0, a_d1, b_d0, b_d1, a_nd, b_nd, a_blow, low_cnt;
        logic b_txd_d1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst.a.txd", 32'(bus_a.txd), 1);
        chk("rst.a.busy", 32'(bus_a.busy), 0);
        chk("rst.a.done", 32'(bus_a.done), 0);
        chk("rst.a.idx", 32'(bus_a.byte_idx), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // One-shot with ignored starts and a start in the done cycle
        start_r = 1'b1;
        step();
        start_r = 1'b0;
        early_done = 0;
        for (int c = 1; c <= 321; c++) begin
            int p, bn;
            p  = c - 1;
            bn = (p % FRAME) / DIV;
            if (p < MSG_CLKS && p % DIV == 4 && bn >= 1 && bn <= 8)
                rx[p / FRAME][bn-1] = bus_a.txd;
            if (c < 321 && bus_a.done) early_done++;
            if (c == 1) begin
                chk("os.c1.txd", 32'(bus_a.txd), 0);
                chk("os.c1.busy", 32'(bus_a.busy), 1);
            end
            if (c == 8) chk("os.c8.txd", 32'(bus_a.txd), 0);
            if (c == 57) chk("os.c57.txd", 32'(bus_a.txd), 1);
            if (c == 81) chk("os.c81.idx", 32'(bus_a.byte_idx), 1);
            if (c == 241) chk("os.c241.idx", 32'(bus_a.byte_idx), 3);
            if (c == 320) chk("os.c320.busy", 32'(bus_a.busy), 1);
            if (c == 321) begin
                chk("os.c321.done", 32'(bus_a.done), 1);
                chk("os.c321.busy", 32'(bus_a.busy), 0);
                chk("os.c321.idx", 32'(bus_a.byte_idx), 0);
            end
            start_r = (c == 50 || c == 200 || c == 321);
            step();
        end
        start_r = 1'b0;
        chk("os.early_done", early_done, 0);
        chk("os.c322.txd", 32'(bus_a.txd), 0);
        chk("os.c322.busy", 32'(bus_a.busy), 1);
        chk("os.rx0", 32'(rx[0]), 32'h40);
        chk("os.rx1", 32'(rx[1]), 32'h30);
        chk("os.rx2", 32'(rx[2]), 32'h2F);
        chk("os.rx3", 32'(rx[3]), 32'h0A);
        repeat (320) step();
        chk("os.second_done", 32'(bus_a.done), 1);
        repeat (5) step();

        // Repeat mode, then drop repeat_en at gap clock 2 of instance a
        rep_r = 1'b1;
        step();
        a_nd = 0; b_nd = 0; a_blow = 0; a_d0 = 0; a_d1 = 0; b_d0 = 0; b_d1 = 0;
        b_txd_d1 = 1'b1;
        for (int c = 1; c <= 972; c++) begin
            if (!bus_a.busy) a_blow++;
            if (bus_a.done) begin
                if (a_nd == 0) a_d0 = c;
                if (a_nd == 1) a_d1 = c;
                a_nd++;
            end
            if (bus_b.done) begin
                if (b_nd == 0) b_d0 = c;
                if (b_nd == 1) begin b_d1 = c; b_txd_d1 = bus_b.txd; end
                b_nd++;
            end
            if (c == 972) rep_r = 1'b0;
            step();
        end
        chk("rep.a.first_done", a_d0, 321);
        chk("rep.a.period", a_d1 - a_d0, 325);
        chk("rep.b.first_done", b_d0, 321);
        chk("rep.b.period", b_d1 - b_d0, 320);
        chk("rep.b.txd_at_done", 32'(b_txd_d1), 0);
        chk("rep.a.busy_low", a_blow, 0);
        chk("gapdrop.a.busy", 32'(bus_a.busy), 0);
        chk("gapdrop.b.busy", 32'(bus_b.busy), 1);
        low_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (!bus_a.txd) low_cnt++;
        end
        chk("gapdrop.a.no_start", low_cnt, 0);

        // Asynchronous reset mid-byte 1
        start_r = 1'b1;
        step();
        start_r = 1'b0;
        repeat (99) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.a.txd", 32'(bus_a.txd), 1);
        chk("arst.a.busy", 32'(bus_a.busy), 0);
        chk("arst.b.txd", 32'(bus_b.txd), 1);
        repeat (2) step();
        rst_n = 1'b1;
        low_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            if (!bus_a.txd || !bus_b.txd) low_cnt++;
        end
        chk("arst.quiet", low_cnt, 0);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            start_r = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) rep_r = ~rep_r;
            step();
        end
        start_r = 1'b0;
        rep_r   = 1'b0;
        repeat (400) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
